br_resolve_unit: RTL

- Parametrised successor to the single-cycle branch/jump decision logic. Resolves all RV32I conditional branches plus jal/jalr.
- Each resolution is registered behind a valid/ready handshake. A BHT of 2-bit saturating counters provides direction prediction to fetch.
- Mispredict/redirect and a saturating mispredict counter go to the pipeline control.
- Sits at the execute stage, between the operand bypass network and the fetch PC mux.

---
 rtl/br_resolve_unit.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/br_resolve_unit.sv
// Execute-stage branch/jump resolver: registered result behind a valid/ready handshake,
// 2-bit saturating BHT for fetch-side direction prediction, saturating mispredict counter.
module br_resolve_unit #(
    parameter int XLEN      = 32,
    parameter int BHT_IDX_W = 6,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [XLEN-1:0]  pred_pc,
    output logic             pred_taken,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [XLEN-1:0]  req_pc,
    input  logic [3:0]       req_op,
    input  logic [XLEN-1:0]  req_imm,
    input  logic [XLEN-1:0]  req_rs1,
    input  logic [XLEN-1:0]  req_rs2,
    input  logic             req_pred_taken,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_taken,
    output logic [XLEN-1:0]  res_target,
    output logic [XLEN-1:0]  res_link,
    output logic             res_mispredict,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int BHT_N = 1 << BHT_IDX_W;

    localparam logic [3:0] OP_BEQ  = 4'b0000;
    localparam logic [3:0] OP_BNE  = 4'b0001;
    localparam logic [3:0] OP_BLT  = 4'b0100;
    localparam logic [3:0] OP_BGE  = 4'b0101;
    localparam logic [3:0] OP_BLTU = 4'b0110;
    localparam logic [3:0] OP_BGEU = 4'b0111;
    localparam logic [3:0] OP_JAL  = 4'b1000;
    localparam logic [3:0] OP_JALR = 4'b1001;

    localparam logic [XLEN-1:0]  PC_STEP  = XLEN'(32'd4);
    localparam logic [XLEN-1:0]  LSB_MASK = ~(XLEN'(32'd1));
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    function automatic logic is_cond_op(input logic [3:0] op);
        case (op)
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: is_cond_op = 1'b1;
            default:                                          is_cond_op = 1'b0;
        endcase
    endfunction

    function automatic logic op_taken(input logic [3:0] op,
                                      input logic [XLEN-1:0] a,
                                      input logic [XLEN-1:0] b);
        case (op)
            OP_BEQ:          op_taken = (a == b);
            OP_BNE:          op_taken = (a != b);
            OP_BLT:          op_taken = ($signed(a) <  $signed(b));
            OP_BGE:          op_taken = ($signed(a) >= $signed(b));
            OP_BLTU:         op_taken = (a <  b);
            OP_BGEU:         op_taken = (a >= b);
            OP_JAL, OP_JALR: op_taken = 1'b1;
            default:         op_taken = 1'b0;
        endcase
    endfunction

    logic [1:0]           bht_r [BHT_N];
    logic                 res_valid_r;
    logic                 res_taken_r;
    logic [XLEN-1:0]      res_target_r;
    logic [XLEN-1:0]      res_link_r;
    logic                 res_mispredict_r;
    logic [CNT_W-1:0]     cnt_r;

    logic                 ready_s;
    logic                 accept_s;
    logic                 taken_s;
    logic                 mispredict_s;
    logic [XLEN-1:0]      link_s;
    logic [XLEN-1:0]      target_s;
    logic [BHT_IDX_W-1:0] pred_idx_s;
    logic [BHT_IDX_W-1:0] req_idx_s;
    logic [1:0]           bht_cur_s;
    logic [1:0]           bht_next_s;
    logic                 bht_we_s;

    // Handshake, condition evaluation and redirect target selection.
    always_comb begin
        ready_s      = !flush && (!res_valid_r || res_ready);
        accept_s     = req_valid && ready_s;
        taken_s      = op_taken(req_op, req_rs1, req_rs2);
        mispredict_s = taken_s ^ req_pred_taken;
        link_s       = req_pc + PC_STEP;
        if (req_op == OP_JALR) begin
            target_s = (req_rs1 + req_imm) & LSB_MASK;
        end else if (taken_s) begin
            target_s = req_pc + req_imm;
        end else begin
            target_s = link_s;
        end
    end

    // BHT indexing (word-aligned PC bits) and saturating counter step.
    always_comb begin
        pred_idx_s = BHT_IDX_W'(pred_pc >> 2);
        req_idx_s  = BHT_IDX_W'(req_pc >> 2);
        bht_cur_s  = bht_r[req_idx_s];
        bht_we_s   = accept_s && is_cond_op(req_op);
        if (taken_s) begin
            bht_next_s = (bht_cur_s == 2'b11) ? 2'b11 : bht_cur_s + 2'b01;
        end else begin
            bht_next_s = (bht_cur_s == 2'b00) ? 2'b00 : bht_cur_s - 2'b01;
        end
    end

    // Prediction table; lookups see the pre-update value in an update cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_N; i++) begin
                bht_r[i] <= 2'b01;
            end
        end else if (bht_we_s) begin
            bht_r[req_idx_s] <= bht_next_s;
        end
    end

    // Result valid: flush wins, then acceptance, then consumer drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_r <= 1'b0;
        end else if (flush) begin
            res_valid_r <= 1'b0;
        end else if (accept_s) begin
            res_valid_r <= 1'b1;
        end else if (res_ready) begin
            res_valid_r <= 1'b0;
        end
    end

    // Result payload loads only on acceptance, otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_taken_r      <= 1'b0;
            res_target_r     <= {XLEN{1'b0}};
            res_link_r       <= {XLEN{1'b0}};
            res_mispredict_r <= 1'b0;
        end else if (accept_s) begin
            res_taken_r      <= taken_s;
            res_target_r     <= target_s;
            res_link_r       <= link_s;
            res_mispredict_r <= mispredict_s;
        end
    end

    // Saturating mispredict counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s && mispredict_s && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    assign pred_taken     = bht_r[pred_idx_s][1];
    assign req_ready      = ready_s;
    assign res_valid      = res_valid_r;
    assign res_taken      = res_taken_r;
    assign res_target     = res_target_r;
    assign res_link       = res_link_r;
    assign res_mispredict = res_mispredict_r;
    assign mispredict_cnt = cnt_r;

endmodule
